// File: rtl/t01_keypad_loader_pkg.sv
// t01_loader_pkg: shared types and key codes for the keypad loader.
// Holds the FSM state encoding, keypad command characters and scroll width.
package t01_loader_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_WRITE  = 4'd2,
    ST_COUNT  = 4'd3,
    ST_RUN    = 4'd4,
    ST_SHOW   = 4'd5,
    ST_FETCH  = 4'd6,
    ST_HOLD   = 4'd7,
    ST_FINISH = 4'd8,
    ST_ERROR  = 4'd9
  } state_e;

  localparam logic [7:0] KEY_COMMIT = 8'h2A;
  localparam logic [7:0] KEY_ENTER  = 8'h23;
  localparam logic [7:0] KEY_DONE   = 8'h44;
  localparam logic [7:0] KEY_CLEAR  = 8'h43;
  localparam logic [7:0] KEY_ZERO   = 8'h30;

  localparam int unsigned SCROLL_W = 20;

endpackage

// File: rtl/t01_keypad_loader_if.sv
// t01_keypad_loader_if: memory request bus between loader and request unit.
// master drives strobes/address/payload; slave returns done and read_data.
interface t01_keypad_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              write_i;
  logic              read_i;
  logic [31:0]       data_adr;
  logic [DATA_W-1:0] write_data;
  logic              done;
  logic [DATA_W-1:0] read_data;

  modport master (
    output write_i, read_i, data_adr, write_data,
    input  done, read_data
  );

  modport slave (
    input  write_i, read_i, data_adr, write_data,
    output done, read_data
  );
endinterface

// File: rtl/t01_req_timer.sv
// t01_req_timer: cycle counter for outstanding memory requests.
// Ports: clk, nRST, clr (restart), inc (count), tc (LIMIT-th cycle reached).
module t01_req_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // tc is high during the LIMIT-th cycle after clr drops
  assign tc = (cnt_q >= W'(LIMIT - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !tc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/t01_keypad_loader.sv
// t01_keypad_loader: keypad program loader, CPU run control, result pager.
// Ports: clk, nRST, en/data/keyvalid (keypad), mem (request bus master),
//  instruction/pc_enable (CPU), write_adr/read_adr/num_adr (bases),
//  display/lcd_en (LCD), fsm_state/err/ovf (status).
// Option T01_LOADER_AUTOSCROLL_EN: HOLD advances after 2^20 idle cycles.
module t01_keypad_loader #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CHARS_PER_WORD = DATA_W / 8,
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] HALT_INSN      = 32'h60002023
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 en,
  input  logic [7:0]           data,
  input  logic                 keyvalid,
  input  logic [31:0]          instruction,
  input  logic [31:0]          write_adr,
  input  logic [31:0]          read_adr,
  input  logic [31:0]          num_adr,
  t01_keypad_loader_if.master  mem,
  output logic                 pc_enable,
  output logic [7:0]           display,
  output logic                 lcd_en,
  output logic [3:0]           fsm_state,
  output logic                 err,
  output logic                 ovf
);
  import t01_loader_pkg::*;

  localparam logic [DATA_W-1:0] PACK_MASK =
    {DATA_W{1'b1}} >> (DATA_W - 8 * CHARS_PER_WORD);
  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  state_e            state_q, state_n;
  logic [31:0]       idx_q, idx_n;
  logic [31:0]       num_q, num_n;
  logic [DATA_W-1:0] pack_q, pack_n;
  logic              wr_q, wr_n;
  logic              rd_q, rd_n;
  logic [31:0]       adr_q, adr_n;
  logic [DATA_W-1:0] wdat_q, wdat_n;
  logic              run_q, run_n;
  logic [7:0]        disp_q, disp_n;
  logic              lcd_q, lcd_n;
  logic              err_q, err_n;
  logic              ovf_q, ovf_n;
  logic              tmr_clr, tmr_inc, tmr_tc;

  logic is_commit, is_enter, is_done, is_clear;
  logic [7:0] rd8;
  logic unused_rd;

  assign is_commit = keyvalid && (data == KEY_COMMIT);
  assign is_enter  = keyvalid && (data == KEY_ENTER);
  assign is_done   = keyvalid && (data == KEY_DONE);
  assign is_clear  = keyvalid && (data == KEY_CLEAR);
  assign rd8       = mem.read_data[7:0];
  assign unused_rd = ^mem.read_data;

  t01_req_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .nRST(nRST),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .tc  (tmr_tc)
  );

`ifdef T01_LOADER_AUTOSCROLL_EN
  logic [SCROLL_W-1:0] scr_q;
  logic                scr_tc;

  assign scr_tc = &scr_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      scr_q <= '0;
    end else if (state_q != ST_HOLD) begin
      scr_q <= '0;
    end else begin
      scr_q <= scr_q + SCROLL_W'(1);
    end
  end
`endif

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    num_n   = num_q;
    pack_n  = pack_q;
    wr_n    = wr_q;
    rd_n    = rd_q;
    adr_n   = adr_q;
    wdat_n  = wdat_q;
    run_n   = run_q;
    disp_n  = disp_q;
    lcd_n   = 1'b0;
    err_n   = err_q;
    ovf_n   = ovf_q;
    tmr_clr = 1'b1;
    tmr_inc = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (en) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (keyvalid) begin
          unique case (1'b1)
            is_commit: begin
              if (idx_q < MAX_W32) begin
                wr_n    = 1'b1;
                adr_n   = write_adr + (idx_q << 2);
                wdat_n  = pack_q;
                state_n = ST_WRITE;
              end else begin
                ovf_n = 1'b1;
              end
            end
            is_enter: begin
              wr_n    = 1'b1;
              adr_n   = num_adr;
              wdat_n  = DATA_W'(idx_q);
              num_n   = idx_q;
              state_n = ST_COUNT;
            end
            default: begin
              pack_n = ((pack_q << 8) | DATA_W'(data))
                       & PACK_MASK;
              disp_n = data;
            end
          endcase
        end
      end
      ST_WRITE, ST_COUNT, ST_FETCH: begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b1;
        // done in the last allowed cycle still completes
        if (mem.done) begin
          wr_n = 1'b0;
          rd_n = 1'b0;
          if (state_q == ST_WRITE) begin
            idx_n   = idx_q + 32'd1;
            pack_n  = '0;
            disp_n  = 8'h00;
            state_n = ST_IDLE;
          end else if (state_q == ST_COUNT) begin
            idx_n   = '0;
            run_n   = 1'b1;
            state_n = ST_RUN;
          end else begin
            disp_n  = (rd8 == 8'h00) ? KEY_ZERO : rd8;
            lcd_n   = 1'b1;
            idx_n   = idx_q + 32'd1;
            state_n = ST_HOLD;
          end
        end else if (tmr_tc) begin
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          run_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ST_ERROR;
        end
      end
      ST_RUN: begin
        if ((instruction == HALT_INSN) || is_done) begin
          run_n   = 1'b0;
          idx_n   = '0;
          state_n = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if ((idx_q == num_q) || is_commit) begin
          state_n = ST_FINISH;
        end else begin
          rd_n    = 1'b1;
          adr_n   = read_adr + (idx_q << 2);
          state_n = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (is_enter) begin
          disp_n  = 8'h00;
          state_n = ST_SHOW;
        end
`ifdef T01_LOADER_AUTOSCROLL_EN
        else if (scr_tc) begin
          disp_n  = 8'h00;
          state_n = ST_SHOW;
        end
`endif
      end
      ST_FINISH, ST_ERROR: begin
        if (is_clear) begin
          idx_n   = '0;
          num_n   = '0;
          pack_n  = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      num_q   <= '0;
      pack_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      run_q   <= 1'b0;
      disp_q  <= '0;
      lcd_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      num_q   <= num_n;
      pack_q  <= pack_n;
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      adr_q   <= adr_n;
      wdat_q  <= wdat_n;
      run_q   <= run_n;
      disp_q  <= disp_n;
      lcd_q   <= lcd_n;
      err_q   <= err_n;
      ovf_q   <= ovf_n;
    end
  end

  assign mem.write_i    = wr_q;
  assign mem.read_i     = rd_q;
  assign mem.data_adr   = adr_q;
  assign mem.write_data = wdat_q;
  assign pc_enable      = run_q;
  assign display        = disp_q;
  assign lcd_en         = lcd_q;
  assign fsm_state      = state_q;
  assign err            = err_q;
  assign ovf            = ovf_q;
endmodule

// File: tb/tb_t01_keypad_loader.sv
// tb_t01_keypad_loader: directed scenarios for the keypad loader.
// Small MAX_WORDS/TIMEOUT_CYCLES keep the run short.
module tb_t01_keypad_loader;
  import t01_loader_pkg::*;

  localparam int unsigned TO = 16;
  localparam logic [31:0] HALT = 32'h60002023;
  localparam logic [31:0] WA = 32'h0000_1000;
  localparam logic [31:0] RA = 32'h0000_2000;
  localparam logic [31:0] NA = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        nRST;
  logic        en;
  logic [7:0]  data;
  logic        keyvalid;
  logic [31:0] instruction;
  logic [31:0] write_adr, read_adr, num_adr;
  logic        pc_enable;
  logic [7:0]  display;
  logic        lcd_en;
  logic [3:0]  fsm_state;
  logic        err, ovf;

  int checks = 0;
  int failures = 0;

  t01_keypad_loader_if #(.DATA_W(32)) mem_if ();

  t01_keypad_loader #(
    .DATA_W(32),
    .CHARS_PER_WORD(4),
    .MAX_WORDS(2),
    .TIMEOUT_CYCLES(TO),
    .HALT_INSN(HALT)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .en(en),
    .data(data),
    .keyvalid(keyvalid),
    .instruction(instruction),
    .write_adr(write_adr),
    .read_adr(read_adr),
    .num_adr(num_adr),
    .mem(mem_if),
    .pc_enable(pc_enable),
    .display(display),
    .lcd_en(lcd_en),
    .fsm_state(fsm_state),
    .err(err),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] ch);
    data = ch;
    keyvalid = 1'b1;
    tick();
    keyvalid = 1'b0;
    data = 8'h00;
  endtask

  task automatic respond(input int w, input logic [31:0] rd);
    repeat (w) tick();
    mem_if.done = 1'b1;
    mem_if.read_data = rd;
    tick();
    mem_if.done = 1'b0;
    mem_if.read_data = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    en = 1'b0;
    data = 8'h00;
    keyvalid = 1'b0;
    instruction = '0;
    write_adr = WA;
    read_adr = RA;
    num_adr = NA;
    mem_if.done = 1'b0;
    mem_if.read_data = '0;
    #3;
    checks++;
    if (fsm_state !== 4'd0) begin
      failures++;
      $display("FAIL rst_state got=%0d exp=0", fsm_state);
    end
    checks++;
    if ({mem_if.write_i, mem_if.read_i, pc_enable, lcd_en, err, ovf}
        !== 6'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=0",
        {mem_if.write_i, mem_if.read_i, pc_enable, lcd_en, err, ovf});
    end
    checks++;
    if ({mem_if.data_adr, display} !== 40'h0) begin
      failures++;
      $display("FAIL rst_bus got=%h exp=0", {mem_if.data_adr, display});
    end
    tick();
    nRST = 1'b1;
    tick();
    checks++;
    if (fsm_state !== 4'd0) begin
      failures++;
      $display("FAIL init_hold got=%0d exp=0", fsm_state);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (fsm_state !== 4'd1) begin
      failures++;
      $display("FAIL init_idle got=%0d exp=1", fsm_state);
    end
  endtask

  task automatic test_pack_write();
    press(8'h31);
    checks++;
    if (display !== 8'h31) begin
      failures++;
      $display("FAIL key_disp got=%h exp=31", display);
    end
    press(8'h32);
    press(KEY_COMMIT);
    checks++;
    if ({mem_if.write_i, mem_if.data_adr, mem_if.write_data, fsm_state}
        !== {1'b1, WA, 32'h3132, 4'd2}) begin
      failures++;
      $display("FAIL wr0 got=%b/%h/%h/%0d exp=1/%h/3132/2", mem_if.write_i,
        mem_if.data_adr, mem_if.write_data, fsm_state, WA);
    end
    press(KEY_ENTER);
    tick();
    tick();
    checks++;
    if ({mem_if.write_i, mem_if.data_adr, mem_if.write_data, fsm_state}
        !== {1'b1, WA, 32'h3132, 4'd2}) begin
      failures++;
      $display("FAIL wr0_hold got=%b/%h/%h/%0d exp=1/%h/3132/2",
        mem_if.write_i, mem_if.data_adr, mem_if.write_data, fsm_state, WA);
    end
    respond(0, 32'h0);
    checks++;
    if ({mem_if.write_i, fsm_state, display} !== {1'b0, 4'd1, 8'h00}) begin
      failures++;
      $display("FAIL wr0_done got=%b/%0d/%h exp=0/1/00",
        mem_if.write_i, fsm_state, display);
    end
  endtask

  task automatic test_overflow();
    press(8'h41);
    press(8'h42);
    press(8'h43);
    press(8'h44);
    press(8'h45);
    checks++;
    if (display !== 8'h45) begin
      failures++;
      $display("FAIL shift_disp got=%h exp=45", display);
    end
    press(KEY_COMMIT);
    checks++;
    if ({mem_if.write_i, mem_if.data_adr, mem_if.write_data}
        !== {1'b1, WA + 32'd4, 32'h42434445}) begin
      failures++;
      $display("FAIL wr1 got=%b/%h/%h exp=1/00001004/42434445",
        mem_if.write_i, mem_if.data_adr, mem_if.write_data);
    end
    respond(1, 32'h0);
    press(KEY_COMMIT);
    checks++;
    if ({mem_if.write_i, ovf, fsm_state} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL ovf got=%b/%b/%0d exp=0/1/1",
        mem_if.write_i, ovf, fsm_state);
    end
    press(KEY_ENTER);
    checks++;
    if ({mem_if.write_i, mem_if.data_adr, mem_if.write_data, fsm_state}
        !== {1'b1, NA, 32'd2, 4'd3}) begin
      failures++;
      $display("FAIL count got=%b/%h/%h/%0d exp=1/%h/2/3", mem_if.write_i,
        mem_if.data_adr, mem_if.write_data, fsm_state, NA);
    end
    respond(0, 32'h0);
    checks++;
    if ({mem_if.write_i, pc_enable, fsm_state} !== {1'b0, 1'b1, 4'd4}) begin
      failures++;
      $display("FAIL run got=%b/%b/%0d exp=0/1/4",
        mem_if.write_i, pc_enable, fsm_state);
    end
  endtask

  task automatic test_run_halt();
    instruction = 32'h0000_0013;
    tick();
    checks++;
    if ({pc_enable, fsm_state} !== {1'b1, 4'd4}) begin
      failures++;
      $display("FAIL run_keep got=%b/%0d exp=1/4", pc_enable, fsm_state);
    end
    instruction = HALT;
    tick();
    instruction = '0;
    checks++;
    if ({pc_enable, fsm_state} !== {1'b0, 4'd5}) begin
      failures++;
      $display("FAIL halt got=%b/%0d exp=0/5", pc_enable, fsm_state);
    end
    tick();
    checks++;
    if ({mem_if.read_i, mem_if.data_adr, fsm_state}
        !== {1'b1, RA, 4'd6}) begin
      failures++;
      $display("FAIL rd0 got=%b/%h/%0d exp=1/%h/6",
        mem_if.read_i, mem_if.data_adr, fsm_state, RA);
    end
  endtask

  task automatic test_fetch_show();
    respond(2, 32'h0);
    checks++;
    if ({display, lcd_en, mem_if.read_i, fsm_state}
        !== {8'h30, 1'b1, 1'b0, 4'd7}) begin
      failures++;
      $display("FAIL rd0_done got=%h/%b/%b/%0d exp=30/1/0/7",
        display, lcd_en, mem_if.read_i, fsm_state);
    end
    tick();
    checks++;
    if (lcd_en !== 1'b0) begin
      failures++;
      $display("FAIL lcd_pulse got=%b exp=0", lcd_en);
    end
    repeat (5) tick();
    checks++;
    if (fsm_state !== 4'd7) begin
      failures++;
      $display("FAIL hold got=%0d exp=7", fsm_state);
    end
    press(KEY_ENTER);
    checks++;
    if ({fsm_state, display} !== {4'd5, 8'h00}) begin
      failures++;
      $display("FAIL hold_next got=%0d/%h exp=5/00", fsm_state, display);
    end
    tick();
    checks++;
    if ({mem_if.read_i, mem_if.data_adr} !== {1'b1, RA + 32'd4}) begin
      failures++;
      $display("FAIL rd1 got=%b/%h exp=1/00002004",
        mem_if.read_i, mem_if.data_adr);
    end
    respond(0, 32'h0000_0141);
    checks++;
    if ({display, lcd_en} !== {8'h41, 1'b1}) begin
      failures++;
      $display("FAIL rd1_done got=%h/%b exp=41/1", display, lcd_en);
    end
    press(KEY_ENTER);
    tick();
    checks++;
    if ({fsm_state, mem_if.read_i} !== {4'd8, 1'b0}) begin
      failures++;
      $display("FAIL finish got=%0d/%b exp=8/0", fsm_state, mem_if.read_i);
    end
    press(KEY_CLEAR);
    checks++;
    if ({fsm_state, ovf} !== {4'd1, 1'b1}) begin
      failures++;
      $display("FAIL clr_fin got=%0d/%b exp=1/1", fsm_state, ovf);
    end
  endtask

  task automatic test_timeout();
    press(KEY_COMMIT);
    checks++;
    if ({mem_if.write_i, mem_if.data_adr, mem_if.write_data}
        !== {1'b1, WA, 32'h0}) begin
      failures++;
      $display("FAIL to_wr got=%b/%h/%h exp=1/%h/0",
        mem_if.write_i, mem_if.data_adr, mem_if.write_data, WA);
    end
    repeat (TO - 1) tick();
    checks++;
    if ({fsm_state, mem_if.write_i, err} !== {4'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL to_early got=%0d/%b/%b exp=2/1/0",
        fsm_state, mem_if.write_i, err);
    end
    tick();
    checks++;
    if ({fsm_state, mem_if.write_i, mem_if.read_i, pc_enable, err}
        !== {4'd9, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL to_err got=%0d/%b/%b/%b/%b exp=9/0/0/0/1", fsm_state,
        mem_if.write_i, mem_if.read_i, pc_enable, err);
    end
    press(KEY_CLEAR);
    checks++;
    if ({fsm_state, err, ovf} !== {4'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL to_clr got=%0d/%b/%b exp=1/1/1", fsm_state, err, ovf);
    end
    press(KEY_COMMIT);
    checks++;
    if (mem_if.data_adr !== WA) begin
      failures++;
      $display("FAIL idx_clr got=%h exp=%h", mem_if.data_adr, WA);
    end
    repeat (TO - 1) tick();
    respond(0, 32'h0);
    checks++;
    if ({fsm_state, mem_if.write_i} !== {4'd1, 1'b0}) begin
      failures++;
      $display("FAIL late_done got=%0d/%b exp=1/0",
        fsm_state, mem_if.write_i);
    end
  endtask

  task automatic test_reset_fetch();
    press(KEY_ENTER);
    checks++;
    if (mem_if.write_data !== 32'd1) begin
      failures++;
      $display("FAIL count1 got=%h exp=1", mem_if.write_data);
    end
    respond(0, 32'h0);
    press(KEY_DONE);
    checks++;
    if ({fsm_state, pc_enable} !== {4'd5, 1'b0}) begin
      failures++;
      $display("FAIL key_d got=%0d/%b exp=5/0", fsm_state, pc_enable);
    end
    tick();
    checks++;
    if ({fsm_state, mem_if.read_i} !== {4'd6, 1'b1}) begin
      failures++;
      $display("FAIL pre_rst got=%0d/%b exp=6/1", fsm_state, mem_if.read_i);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({fsm_state, mem_if.read_i, mem_if.write_i, pc_enable, err, ovf,
         display} !== 17'h0) begin
      failures++;
      $display("FAIL async_rst got=%0d/%b/%b/%b/%b/%b/%h exp=all 0",
        fsm_state, mem_if.read_i, mem_if.write_i, pc_enable, err, ovf,
        display);
    end
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pack_write();
    test_overflow();
    test_run_halt();
    test_fetch_show();
    test_timeout();
    test_reset_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
